// File: rtl/hilo_acc.sv
// HI/LO special-register pair with independent half-writes and a two-cycle
// multiply-accumulate path (MADD/MSUB family), with bypassed reads and a busy flag.
module hilo_acc #(
    parameter int unsigned W      = 32,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic           cpu_clk_75M,
    input  logic           cpu_rst_n,
    input  logic           we_hi_i,
    input  logic           we_lo_i,
    input  logic [W-1:0]   hi_i,
    input  logic [W-1:0]   lo_i,
    input  logic           acc_valid_i,
    input  logic           acc_sub_i,
    input  logic [2*W-1:0] acc_prod_i,
    input  logic           flush_i,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o,
    output logic [W-1:0]   hi_fwd_o,
    output logic [W-1:0]   lo_fwd_o,
    output logic           busy_o
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [2*W-1:0]   r_prod;
    logic             r_sub;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_accept;
    logic             w_commit;
    logic [2*W-1:0]   w_acc;
    logic [W-1:0]     w_hi_d;
    logic [W-1:0]     w_lo_d;

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ACC_EN && acc_valid_i && !flush_i) begin
                    w_accept  = 1'b1;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                // Requests arriving here are dropped; flush discards the in-flight op.
                w_commit  = !flush_i;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Commit uses the HI/LO held during the BUSY cycle, so accept-cycle writes count.
    assign w_acc = r_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

    always_comb begin
        w_hi_d = r_hi;
        w_lo_d = r_lo;
        if (w_commit) begin
            w_hi_d = w_acc[2*W-1:W];
            w_lo_d = w_acc[W-1:0];
        end
        if (we_hi_i) w_hi_d = hi_i;
        if (we_lo_i) w_lo_d = lo_i;
    end

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= StIdle;
            r_prod  <= '0;
            r_sub   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
            if (w_accept) begin
                r_prod <= acc_prod_i;
                r_sub  <= acc_sub_i;
            end
        end
    end

    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign hi_fwd_o = we_hi_i ? hi_i : r_hi;
    assign lo_fwd_o = we_lo_i ? lo_i : r_lo;
    assign busy_o   = (r_state == StBusy);

endmodule

// File: doc/hilo_acc.md
# hilo_acc

Parametrised HI/LO special-register block with independent half-writes and a two-cycle multiply-accumulate (MADD/MSUB family) path. It replaces the plain single-enable HI/LO pair in the execute/writeback boundary of the pipeline. It accepts MTHI/MTLO/MULT/DIV results as direct writes and MADD(U)/MSUB(U) products as accumulate requests. It exposes both architectural and bypassed read values plus a busy flag for hazard control.

## Interface
- W, 32, data width of each half (HI and LO); the accumulator is 2W bits.
- ACC_EN, 1, 1 enables the accumulate path; 0 ties busy_o low and ignores acc_valid_i.

- cpu_clk_75M  in  1  pipeline clock.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- we_hi_i  in  1  direct write enable for HI.
- we_lo_i  in  1  direct write enable for LO.
- hi_i  in  W  direct write data for HI.
- lo_i  in  W  direct write data for LO.
- acc_valid_i  in  1  accumulate request; accepted only when busy_o=0.
- acc_sub_i  in  1  0 = add (MADD/MADDU), 1 = subtract (MSUB/MSUBU).
- acc_prod_i  in  2W  product from the multiplier, already sign/zero-extended by the producer.
- flush_i  in  1  cancels an in-flight accumulate (exception/eret).
- hi_o  out  W  architectural HI.
- lo_o  out  W  architectural LO.
- hi_fwd_o  out  W  bypassed HI: hi_i when we_hi_i=1, else hi_o.
- lo_fwd_o  out  W  bypassed LO: lo_i when we_lo_i=1, else lo_o.
- busy_o  out  1  accumulate in flight; consumers of HI/LO must stall.

## Operation
- Reset (asynchronous, cpu_rst_n=0): hi_o=0, lo_o=0, busy_o=0, stage-1 product and op registers cleared. Asynchronous assertion; synchronous release on the next edge.
- Direct write: we_hi_i loads hi_i and we_lo_i loads lo_i at the clock edge. The halves are independent.
- Accumulate, a two-state FSM:
  - IDLE. Entered at reset. acc_valid_i=1 and flush_i=0 → capture acc_prod_i and acc_sub_i into stage 1, go to BUSY. Otherwise stay in IDLE.
  - BUSY (busy_o=1). flush_i=0 → commit {hi_o,lo_o} <= {hi_o,lo_o} ± prod, then go to IDLE. flush_i=1 → discard with no commit, then go to IDLE.
- Commit uses the HI/LO values present in the BUSY cycle. A direct write made in the accept cycle is therefore included in the accumulation.
- Arithmetic is 2W-bit modular add or subtract. It wraps silently and has no overflow flag. The result's upper W bits go to hi_o and lower W bits to lo_o.
- Direct write and commit in the same cycle: for each half, the direct write wins. The other half still takes the accumulate result.
- acc_valid_i while busy_o=1 is a protocol violation. The request is dropped and the in-flight op is unaffected.
- ACC_EN=0: the FSM stays in IDLE and only direct writes act.

## Timing
- Direct write: data is presented in cycle T and is visible on hi_o/lo_o in cycle T+1. It is visible on hi_fwd_o/lo_fwd_o in cycle T, combinationally.
- Accumulate:
  - Accepted in cycle T.
  - busy_o=1 in cycle T+1 only.
  - Result visible on hi_o/lo_o in cycle T+2.
- Maximum throughput is one accumulate per 2 cycles. A new acc_valid_i may be accepted in cycle T+2.
- busy_o is driven from a register with no combinational path from the inputs.
- flush_i is sampled only in the accept cycle and in the BUSY cycle. It has no effect on direct writes.
- Fwd outputs do not reflect an in-flight accumulate. busy_o covers that hazard.

## Test plan
- Reset mid-operation: accept an accumulate with prod=0x1, then assert cpu_rst_n=0 in the BUSY cycle → hi_o=lo_o=0 and busy_o=0 immediately; no commit after release.
- Independent writes: we_lo_i=1 with lo_i=0xDEADBEEF → lo_o=0xDEADBEEF next cycle and hi_o unchanged. lo_fwd_o=0xDEADBEEF in the same cycle.
- MADD carry: HI/LO=0x00000000_FFFFFFFF, add prod=0x1 → busy_o pulses 1 cycle, and in cycle T+2 hi_o=0x00000001, lo_o=0x00000000.
- MSUB wrap: HI/LO=0, subtract prod=0x1 → hi_o=lo_o=0xFFFFFFFF. Back-to-back acc_valid_i in the BUSY cycle is dropped, so only one result appears.
- Collision: in the BUSY cycle (prod=0x00000002_00000003, add, HI/LO=0), assert we_hi_i with hi_i=0x55 → hi_o=0x55, lo_o=0x3.
- Flush: accumulate accepted, flush_i=1 in the BUSY cycle → HI/LO unchanged and busy_o=0 next cycle. A new accumulate is accepted immediately afterwards.
